// File: rtl/axi_wresp_router_if.sv
// B-channel bundle between the response arbiter (upstream) and the per-master
// response ports. The router connects through the slave modport.
interface axi_wresp_router_if #(
  parameter int NUM_MASTERS     = 4,
  parameter int MASTER_ID_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int TXN_ID_WIDTH    = 4
);
  logic [MASTER_ID_WIDTH+TXN_ID_WIDTH-1:0] in_bid;
  logic [1:0]                              in_bresp;
  logic                                    in_bvalid;
  logic                                    in_bready;
  logic [NUM_MASTERS*TXN_ID_WIDTH-1:0]     m_bid;
  logic [NUM_MASTERS*2-1:0]                m_bresp;
  logic [NUM_MASTERS-1:0]                  m_bvalid;
  logic [NUM_MASTERS-1:0]                  m_bready;
  logic [NUM_MASTERS-1:0]                  fifo_full;
  logic                                    unmapped_pulse;
  logic [15:0]                             unmapped_count;

  modport slave (
    input  in_bid, in_bresp, in_bvalid, m_bready,
    output in_bready, m_bid, m_bresp, m_bvalid, fifo_full,
           unmapped_pulse, unmapped_count
  );

  modport master (
    output in_bid, in_bresp, in_bvalid, m_bready,
    input  in_bready, m_bid, m_bresp, m_bvalid, fifo_full,
           unmapped_pulse, unmapped_count
  );
endinterface

// File: rtl/axi_wresp_router.sv
// Routes write responses to per-master FIFOs by the master-index bits of the ID;
// responses whose index has no master are accepted, dropped and counted.
module axi_wresp_router #(
  parameter int NUM_MASTERS     = 4,
  parameter int MASTER_ID_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int TXN_ID_WIDTH    = 4,
  parameter int FIFO_DEPTH      = 2
) (
  input logic               ACLK,
  input logic               ARESET,
  axi_wresp_router_if.slave bus
);

  localparam int ENTRY_W = TXN_ID_WIDTH + 2;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [MASTER_ID_WIDTH-1:0] idx;
  logic [TXN_ID_WIDTH-1:0]    txn;
  logic                       mapped;
  logic                       drop;

  logic [ENTRY_W-1:0] mem_q    [NUM_MASTERS][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_MASTERS];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_MASTERS];
  logic [CNT_W-1:0]   cnt_q    [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] full;
  logic [NUM_MASTERS-1:0] nonempty;
  logic [NUM_MASTERS-1:0] push;
  logic [NUM_MASTERS-1:0] pop;
  logic                   in_ready;

  logic [NUM_MASTERS*TXN_ID_WIDTH-1:0] m_bid_c;
  logic [NUM_MASTERS*2-1:0]            m_bresp_c;

  logic        unmapped_pulse_q;
  logic [15:0] unmapped_cnt_q;

  assign idx    = bus.in_bid[TXN_ID_WIDTH +: MASTER_ID_WIDTH];
  assign txn    = bus.in_bid[TXN_ID_WIDTH-1:0];
  assign mapped = (int'(idx) < NUM_MASTERS);
  assign drop   = bus.in_bvalid & ~mapped;

  // Ready depends only on the ID and registered occupancy, never on in_bvalid;
  // a full FIFO refuses even when it pops in the same cycle.
  always_comb begin
    in_ready = 1'b1;
    full     = '0;
    nonempty = '0;
    push     = '0;
    pop      = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      full[k]     = (cnt_q[k] == CNT_FULL);
      nonempty[k] = (cnt_q[k] != '0);
      pop[k]      = nonempty[k] & bus.m_bready[k];
      if (mapped && (int'(idx) == k)) begin
        in_ready = ~full[k];
        push[k]  = bus.in_bvalid & ~full[k];
      end
    end
  end

  always_comb begin
    m_bid_c   = '0;
    m_bresp_c = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (nonempty[k]) begin
        {m_bid_c[k*TXN_ID_WIDTH +: TXN_ID_WIDTH], m_bresp_c[k*2 +: 2]} =
          mem_q[k][rd_ptr_q[k]];
      end
    end
  end

  // Storage needs no reset: the head is only visible while the count is non-zero.
  always_ff @(posedge ACLK) begin
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (push[k]) begin
        mem_q[k][wr_ptr_q[k]] <= {txn, bus.in_bresp};
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      unmapped_pulse_q <= 1'b0;
      unmapped_cnt_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (push[k]) begin
          wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        end
        if (pop[k]) begin
          rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        end
        if (push[k] && !pop[k]) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end else if (!push[k] && pop[k]) begin
          cnt_q[k] <= cnt_q[k] - 1'b1;
        end
      end
      unmapped_pulse_q <= drop;
      if (drop && (unmapped_cnt_q != 16'hFFFF)) begin
        unmapped_cnt_q <= unmapped_cnt_q + 16'd1;
      end
    end
  end

  assign bus.in_bready      = in_ready;
  assign bus.m_bid          = m_bid_c;
  assign bus.m_bresp        = m_bresp_c;
  assign bus.m_bvalid       = nonempty;
  assign bus.fifo_full      = full;
  assign bus.unmapped_pulse = unmapped_pulse_q;
  assign bus.unmapped_count = unmapped_cnt_q;

endmodule

// File: tb/tb_axi_wresp_router.sv
// Directed bench for axi_wresp_router: a 4-master instance checked by a queue
// scoreboard, plus a 3-master instance that exercises unmapped-ID dropping.
module tb_axi_wresp_router;
  localparam int NM = 4;
  localparam int TW = 4;

  logic ACLK   = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  axi_wresp_router_if #(.NUM_MASTERS(4), .MASTER_ID_WIDTH(2), .TXN_ID_WIDTH(4)) bus ();
  axi_wresp_router_if #(.NUM_MASTERS(3), .MASTER_ID_WIDTH(2), .TXN_ID_WIDTH(4)) bus3 ();

  axi_wresp_router #(.NUM_MASTERS(4), .MASTER_ID_WIDTH(2), .TXN_ID_WIDTH(4), .FIFO_DEPTH(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus)
  );

  axi_wresp_router #(.NUM_MASTERS(3), .MASTER_ID_WIDTH(2), .TXN_ID_WIDTH(4), .FIFO_DEPTH(2)) dut3 (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus3)
  );

  int checks = 0;
  int errors = 0;
  logic [TW+1:0] exp_q [NM][$];
  logic [TW+1:0] mon_e;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every visible head must match the oldest expected entry.
  always @(negedge ACLK) begin
    if (mon_en && !ARESET) begin
      for (int k = 0; k < NM; k++) begin
        if (bus.m_bvalid[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid m%0d: got bid 0x%0h, expected no response at %0t",
                     k, bus.m_bid[k*TW +: TW], $time);
          end else begin
            mon_e = exp_q[k][0];
            chk($sformatf("m%0d_bid", k), 32'(bus.m_bid[k*TW +: TW]), 32'(mon_e[TW+1:2]));
            chk($sformatf("m%0d_bresp", k), 32'(bus.m_bresp[k*2 +: 2]), 32'(mon_e[1:0]));
            if (bus.m_bready[k]) void'(exp_q[k].pop_front());
          end
        end else begin
          chk($sformatf("m%0d_idle_bid", k), 32'(bus.m_bid[k*TW +: TW]), 32'd0);
          chk($sformatf("m%0d_idle_bresp", k), 32'(bus.m_bresp[k*2 +: 2]), 32'd0);
        end
      end
    end
  end

  // Called at posedge+1; holds the response for one cycle and returns at posedge+1.
  task automatic offer(input logic [1:0] m, input logic [3:0] t, input logic [1:0] r,
                       input logic exp_rdy, input string name);
    bus.in_bid    = {m, t};
    bus.in_bresp  = r;
    bus.in_bvalid = 1'b1;
    @(negedge ACLK);
    chk(name, 32'(bus.in_bready), 32'(exp_rdy));
    if (exp_rdy) exp_q[m].push_back({t, r});
    @(posedge ACLK); #1;
    bus.in_bvalid = 1'b0;
  endtask

  initial begin
    bus.in_bid     = '0;
    bus.in_bresp   = '0;
    bus.in_bvalid  = 1'b0;
    bus.m_bready   = '1;
    bus3.in_bid    = '0;
    bus3.in_bresp  = '0;
    bus3.in_bvalid = 1'b0;
    bus3.m_bready  = '1;

    // reset values
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_bvalid", 32'(bus.m_bvalid), 32'd0);
    chk("rst_bid", 32'(bus.m_bid), 32'd0);
    chk("rst_bresp", 32'(bus.m_bresp), 32'd0);
    chk("rst_full", 32'(bus.fifo_full), 32'd0);
    chk("rst_pulse", 32'(bus.unmapped_pulse), 32'd0);
    chk("rst_count", 32'(bus.unmapped_count), 32'd0);
    chk("rst3_bvalid", 32'(bus3.m_bvalid), 32'd0);
    chk("rst3_count", 32'(bus3.unmapped_count), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    mon_en = 1'b1;

    // idle: ready for every ID
    for (int b = 0; b < 64; b++) begin
      bus.in_bid  = 6'(b);
      bus3.in_bid = 6'(b);
      #1;
      chk($sformatf("idle_rdy_%0d", b), 32'(bus.in_bready), 32'd1);
      chk($sformatf("idle3_rdy_%0d", b), 32'(bus3.in_bready), 32'd1);
    end
    @(posedge ACLK); #1;

    // single route
    offer(2'd2, 4'h5, 2'b10, 1'b1, "route_rdy");
    @(negedge ACLK);
    chk("route_bvalid", 32'(bus.m_bvalid), 32'b0100);
    chk("route_bid", 32'(bus.m_bid[2*TW +: TW]), 32'h5);
    chk("route_bresp", 32'(bus.m_bresp[4 +: 2]), 32'd2);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("route_popped", 32'(bus.m_bvalid), 32'd0);
    @(posedge ACLK); #1;

    // backpressure on master 1
    bus.m_bready = 4'b1101;
    offer(2'd1, 4'h1, 2'b00, 1'b1, "bp_acc1");
    offer(2'd1, 4'h2, 2'b01, 1'b1, "bp_acc2");
    @(negedge ACLK);
    chk("bp_full", 32'(bus.fifo_full), 32'b0010);
    @(posedge ACLK); #1;
    bus.in_bid    = {2'd1, 4'h3};
    bus.in_bresp  = 2'b10;
    bus.in_bvalid = 1'b1;
    @(negedge ACLK);
    chk("bp_blocked", 32'(bus.in_bready), 32'd0);
    @(posedge ACLK); #1;
    bus.m_bready = 4'b1111;
    @(negedge ACLK);
    chk("bp_no_bypass", 32'(bus.in_bready), 32'd0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("bp_accept3", 32'(bus.in_bready), 32'd1);
    exp_q[1].push_back({4'h3, 2'b10});
    @(posedge ACLK); #1;
    bus.in_bvalid = 1'b0;
    repeat (4) @(posedge ACLK); #1;

    // independence: master 0 stalled and full, master 3 still flows
    bus.m_bready = 4'b1110;
    offer(2'd0, 4'h7, 2'b01, 1'b1, "ind_acc0a");
    offer(2'd0, 4'h8, 2'b11, 1'b1, "ind_acc0b");
    offer(2'd0, 4'hA, 2'b00, 1'b0, "ind_hol_blocked");
    offer(2'd3, 4'h9, 2'b10, 1'b1, "ind_m3_rdy");
    @(negedge ACLK);
    chk("ind_m3_valid", 32'(bus.m_bvalid), 32'b1001);
    chk("ind_full", 32'(bus.fifo_full), 32'b0001);
    @(posedge ACLK); #1;
    repeat (2) @(posedge ACLK); #1;
    bus.m_bready = 4'b1111;
    repeat (4) @(posedge ACLK); #1;

    // simultaneous push and pop at count 1 on master 2
    bus.m_bready = 4'b1011;
    offer(2'd2, 4'h1, 2'b00, 1'b1, "sim_acc1");
    bus.m_bready = 4'b1111;
    offer(2'd2, 4'h2, 2'b01, 1'b1, "sim_acc2_pop1");
    bus.m_bready = 4'b1011;
    @(negedge ACLK);
    chk("sim_valid", 32'(bus.m_bvalid[2]), 32'd1);
    chk("sim_not_full", 32'(bus.fifo_full[2]), 32'd0);
    @(posedge ACLK); #1;
    offer(2'd2, 4'h3, 2'b11, 1'b1, "sim_acc3");
    @(negedge ACLK);
    chk("sim_full", 32'(bus.fifo_full[2]), 32'd1);
    @(posedge ACLK); #1;
    bus.m_bready = 4'b1111;
    repeat (4) @(posedge ACLK); #1;

    // reset with two entries queued; a concurrent handshake must be ignored
    bus.m_bready = 4'b1101;
    offer(2'd1, 4'h4, 2'b00, 1'b1, "rst_acc1");
    offer(2'd1, 4'h5, 2'b01, 1'b1, "rst_acc2");
    @(negedge ACLK);
    chk("rst_pre_full", 32'(bus.fifo_full), 32'b0010);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    for (int k = 0; k < NM; k++) exp_q[k].delete();
    bus.in_bid    = {2'd0, 4'hC};
    bus.in_bresp  = 2'b01;
    bus.in_bvalid = 1'b1;
    @(posedge ACLK); #1;
    bus.in_bvalid = 1'b0;
    @(negedge ACLK);
    chk("rst_mid_bvalid", 32'(bus.m_bvalid), 32'd0);
    chk("rst_mid_full", 32'(bus.fifo_full), 32'd0);
    @(posedge ACLK); #1;
    ARESET       = 1'b0;
    bus.m_bready = 4'b1111;
    repeat (3) @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("rst_after_bvalid", 32'(bus.m_bvalid), 32'd0);
    @(posedge ACLK); #1;

    // unmapped IDs on the 3-master instance
    bus3.in_bid    = {2'd3, 4'h6};
    bus3.in_bresp  = 2'b11;
    bus3.in_bvalid = 1'b1;
    @(negedge ACLK);
    chk("unm_rdy", 32'(bus3.in_bready), 32'd1);
    chk("unm_pulse_pre", 32'(bus3.unmapped_pulse), 32'd0);
    @(posedge ACLK); #1;
    bus3.in_bvalid = 1'b0;
    @(negedge ACLK);
    chk("unm_pulse", 32'(bus3.unmapped_pulse), 32'd1);
    chk("unm_count1", 32'(bus3.unmapped_count), 32'd1);
    chk("unm_no_valid", 32'(bus3.m_bvalid), 32'd0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("unm_pulse_end", 32'(bus3.unmapped_pulse), 32'd0);
    chk("unm_count_hold", 32'(bus3.unmapped_count), 32'd1);
    @(posedge ACLK); #1;
    bus3.in_bvalid = 1'b1;
    repeat (65534) @(posedge ACLK);
    #1;
    chk("unm_count_max", 32'(bus3.unmapped_count), 32'hFFFF);
    @(posedge ACLK); #1;
    chk("unm_count_sat", 32'(bus3.unmapped_count), 32'hFFFF);
    chk("unm_pulse_sat", 32'(bus3.unmapped_pulse), 32'd1);
    chk("unm_sat_no_valid", 32'(bus3.m_bvalid), 32'd0);
    bus3.in_bvalid = 1'b0;

    repeat (3) @(posedge ACLK); #1;
    for (int k = 0; k < NM; k++) begin
      chk($sformatf("drain_m%0d", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
